// File: rtl/window_matcher.sv
// rtl/window_matcher.sv - 16x16 window SAD matcher with per-frame best-match tracking
//
// Purpose: accepts one 16x16 byte window per cycle, computes its sum of
// absolute differences against a stored template in a 4-stage pipeline and
// keeps the minimum SAD and its (row, col) across a frame.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begins a frame (IDLE only)
//   window_data       window bytes [row][col], valid with window_ready
//   window_ready      one-cycle window strobe from the producer
//   frame_done        producer has sent the last window of the frame
//   receive           registered acknowledge, one cycle per accepted window
//   tmpl_wr/addr/data template word write (IDLE only), 4 bytes per word
//   busy              high whenever not IDLE
//   result_valid      one-cycle pulse when the frame result is final
//   best_sad          minimum SAD in the frame
//   best_row/col      position of the best window
//   overflow          sticky: more than POS*POS windows arrived this frame
module window_matcher #(
  parameter int N   = 16,
  parameter int POS = 65,
  parameter int LAT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [N-1:0][N-1:0][7:0] window_data,
  input  logic                    window_ready,
  input  logic                    frame_done,
  output logic                    receive,
  input  logic                    tmpl_wr,
  input  logic [5:0]              tmpl_addr,
  input  logic [31:0]             tmpl_data,
  output logic                    busy,
  output logic                    result_valid,
  output logic [15:0]             best_sad,
  output logic [6:0]              best_row,
  output logic [6:0]              best_col,
  output logic                    overflow
);

  localparam int          DW      = $clog2(LAT + 1);
  localparam logic [12:0] MAX_WIN = 13'(POS * POS);
  localparam logic [6:0]  LAST_C  = 7'(POS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_REPORT} state_t;

  state_t r_state, w_next;
  logic [DW-1:0] r_drain;

  logic [N-1:0][N-1:0][7:0] r_tmpl;

  logic [12:0] r_win_cnt;
  logic [6:0]  r_win_row, r_win_col;

  logic w_start, w_accept, w_drop;

  // Pipeline data and position tags travelling with each window.
  logic [N-1:0][N-1:0][7:0] w_diff, r_diff;
  logic [N-1:0][11:0]       w_row_sum, r_row_sum;
  logic [15:0]              w_total, r_total;
  logic                     r_v1, r_v2, r_v3;
  logic [6:0]               r_row1, r_col1, r_row2, r_col2, r_row3, r_col3;

  assign w_start  = (r_state == S_IDLE) && start;
  assign w_accept = (r_state == S_RUN) && window_ready && (r_win_cnt < MAX_WIN);
  assign w_drop   = (r_state == S_RUN) && window_ready && (r_win_cnt == MAX_WIN);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_drain <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DRAIN) r_drain <= r_drain + 1'b1;
      else                    r_drain <= '0;
    end
  end

  always_comb begin
    w_next       = r_state;
    busy         = 1'b1;
    result_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_RUN;
      end
      S_RUN:    if (frame_done) w_next = S_DRAIN;
      // DRAIN lasts LAT cycles so the last accepted window reaches the best register.
      S_DRAIN:  if (r_drain == DW'(LAT - 1)) w_next = S_REPORT;
      S_REPORT: begin
        result_valid = 1'b1;
        w_next       = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // ---------------- Template RAM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmpl <= '0;
    end else if (tmpl_wr && (r_state == S_IDLE)) begin
      for (int k = 0; k < 4; k++)
        r_tmpl[tmpl_addr[5:2]][{tmpl_addr[1:0], 2'(k)}] <= tmpl_data[8*k +: 8];
    end
  end

  // ---------------- Window accounting ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_cnt <= '0;
      r_win_row <= '0;
      r_win_col <= '0;
      overflow  <= 1'b0;
      receive   <= 1'b0;
    end else begin
      receive <= w_accept;
      if (w_start) begin
        r_win_cnt <= '0;
        r_win_row <= '0;
        r_win_col <= '0;
        overflow  <= 1'b0;
      end else if (w_accept) begin
        r_win_cnt <= r_win_cnt + 1'b1;
        if (r_win_col == LAST_C) begin
          r_win_col <= '0;
          r_win_row <= r_win_row + 1'b1;
        end else begin
          r_win_col <= r_win_col + 1'b1;
        end
      end else if (w_drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------- SAD pipeline ----------------
  always_comb begin
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        w_diff[r][c] = (window_data[r][c] > r_tmpl[r][c]) ? window_data[r][c] - r_tmpl[r][c]
                                                          : r_tmpl[r][c] - window_data[r][c];
  end

  always_comb begin
    for (int r = 0; r < N; r++) begin
      w_row_sum[r] = '0;
      for (int c = 0; c < N; c++)
        w_row_sum[r] = w_row_sum[r] + 12'(r_diff[r][c]);
    end
  end

  always_comb begin
    w_total = '0;
    for (int r = 0; r < N; r++)
      w_total = w_total + 16'(r_row_sum[r]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_diff    <= '0;
      r_row_sum <= '0;
      r_total   <= '0;
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_v3      <= 1'b0;
      r_row1    <= '0;
      r_col1    <= '0;
      r_row2    <= '0;
      r_col2    <= '0;
      r_row3    <= '0;
      r_col3    <= '0;
    end else begin
      r_diff    <= w_diff;
      r_row_sum <= w_row_sum;
      r_total   <= w_total;
      r_v1      <= w_accept && !w_start;
      r_v2      <= r_v1 && !w_start;
      r_v3      <= r_v2 && !w_start;
      r_row1    <= r_win_row;
      r_col1    <= r_win_col;
      r_row2    <= r_row1;
      r_col2    <= r_col1;
      r_row3    <= r_row2;
      r_col3    <= r_col2;
    end
  end

  // Strict less-than: on a tie the earlier window keeps the best slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_sad <= 16'hFFFF;
      best_row <= '0;
      best_col <= '0;
    end else if (w_start) begin
      best_sad <= 16'hFFFF;
      best_row <= '0;
      best_col <= '0;
    end else if (r_v3 && (r_total < best_sad)) begin
      best_sad <= r_total;
      best_row <= r_row3;
      best_col <= r_col3;
    end
  end

endmodule
